// File: rtl/cacheline_arbiter.sv
// Cacheline arbiter: merges I-cache and D-cache line requests onto one burst
// memory port and splits each cacheline into sequential beats. D-side wins
// ties because a D miss stalls the whole pipeline.
module cacheline_arbiter #(
    parameter int BEATS  = 4,
    parameter int BEAT_W = 64,
    parameter int LINE_W = 256   // must equal BEATS*BEAT_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [31:0]       icache_pmem_address,
    input  logic              icache_pmem_read,
    output logic [LINE_W-1:0] icache_pmem_rdata,
    output logic              icache_pmem_resp,
    input  logic [31:0]       dcache_pmem_address,
    input  logic              dcache_pmem_read,
    input  logic              dcache_pmem_write,
    input  logic [LINE_W-1:0] dcache_pmem_wdata,
    output logic [LINE_W-1:0] dcache_pmem_rdata,
    output logic              dcache_pmem_resp,
    output logic [31:0]       bmem_address,
    output logic              bmem_read,
    output logic              bmem_write,
    output logic [BEAT_W-1:0] bmem_wdata,
    input  logic [BEAT_W-1:0] bmem_rdata,
    input  logic              bmem_resp
);

    localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int OFF_W = $clog2(LINE_W / 8);

    typedef enum logic [1:0] {IDLE, RD_BURST, WR_BURST, DONE} state_t;

    state_t            state, state_nxt;
    logic              owner_d;      // 1: D-cache owns the port, 0: I-cache
    logic [CNT_W-1:0]  cnt;
    logic [LINE_W-1:0] line_q;
    logic [LINE_W-1:0] wdata_q;
    logic [31:0]       addr_q;
    logic              last_beat;

    assign last_beat = bmem_resp && (cnt == CNT_W'(BEATS - 1));

    // State register
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next-state: write beats read on the D side, D beats I, beats advance on resp
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (dcache_pmem_write)     state_nxt = WR_BURST;
                else if (dcache_pmem_read) state_nxt = RD_BURST;
                else if (icache_pmem_read) state_nxt = RD_BURST;
            end
            RD_BURST: if (last_beat) state_nxt = DONE;
            WR_BURST: if (last_beat) state_nxt = DONE;
            DONE:     state_nxt = IDLE;
            default:  state_nxt = IDLE;
        endcase
    end

    // Datapath: grant latching in IDLE, beat assembly and counting in bursts
    always_ff @(posedge clk) begin
        if (rst) begin
            owner_d <= 1'b0;
            cnt     <= '0;
            line_q  <= '0;
            wdata_q <= '0;
            addr_q  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    cnt <= '0;
                    if (dcache_pmem_write) begin
                        owner_d <= 1'b1;
                        addr_q  <= {dcache_pmem_address[31:OFF_W], OFF_W'(0)};
                        wdata_q <= dcache_pmem_wdata;
                    end else if (dcache_pmem_read) begin
                        owner_d <= 1'b1;
                        addr_q  <= {dcache_pmem_address[31:OFF_W], OFF_W'(0)};
                    end else if (icache_pmem_read) begin
                        owner_d <= 1'b0;
                        addr_q  <= {icache_pmem_address[31:OFF_W], OFF_W'(0)};
                    end
                end
                RD_BURST: begin
                    if (bmem_resp) begin
                        line_q[BEAT_W*cnt +: BEAT_W] <= bmem_rdata;
                        cnt <= cnt + 1'b1;
                    end
                end
                WR_BURST: begin
                    if (bmem_resp) cnt <= cnt + 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Outputs: memory strobes from state, one-cycle resp to the owner in DONE
    always_comb begin
        bmem_read        = (state == RD_BURST);
        bmem_write       = (state == WR_BURST);
        bmem_address     = (bmem_read || bmem_write) ? addr_q : '0;
        bmem_wdata       = bmem_write ? wdata_q[BEAT_W*cnt +: BEAT_W] : '0;
        icache_pmem_resp = (state == DONE) && !owner_d;
        dcache_pmem_resp = (state == DONE) &&  owner_d;
    end

    // Line buffer is presented continuously; consumers sample on resp only
    assign icache_pmem_rdata = line_q;
    assign dcache_pmem_rdata = line_q;

endmodule

// File: tb/tb_cacheline_arbiter.sv
// Self-checking bench for cacheline_arbiter: scoreboard of expected bursts,
// bench-side memory model serving beats with optional gaps.
module tb_cacheline_arbiter;

    logic         clk;
    logic         rst;
    logic [31:0]  icache_pmem_address;
    logic         icache_pmem_read;
    logic [255:0] icache_pmem_rdata;
    logic         icache_pmem_resp;
    logic [31:0]  dcache_pmem_address;
    logic         dcache_pmem_read;
    logic         dcache_pmem_write;
    logic [255:0] dcache_pmem_wdata;
    logic [255:0] dcache_pmem_rdata;
    logic         dcache_pmem_resp;
    logic [31:0]  bmem_address;
    logic         bmem_read;
    logic         bmem_write;
    logic [63:0]  bmem_wdata;
    logic [63:0]  bmem_rdata;
    logic         bmem_resp;

    cacheline_arbiter dut (
        .clk                 (clk),
        .rst                 (rst),
        .icache_pmem_address (icache_pmem_address),
        .icache_pmem_read    (icache_pmem_read),
        .icache_pmem_rdata   (icache_pmem_rdata),
        .icache_pmem_resp    (icache_pmem_resp),
        .dcache_pmem_address (dcache_pmem_address),
        .dcache_pmem_read    (dcache_pmem_read),
        .dcache_pmem_write   (dcache_pmem_write),
        .dcache_pmem_wdata   (dcache_pmem_wdata),
        .dcache_pmem_rdata   (dcache_pmem_rdata),
        .dcache_pmem_resp    (dcache_pmem_resp),
        .bmem_address        (bmem_address),
        .bmem_read           (bmem_read),
        .bmem_write          (bmem_write),
        .bmem_wdata          (bmem_wdata),
        .bmem_rdata          (bmem_rdata),
        .bmem_resp           (bmem_resp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit           is_d;
        bit           is_wr;
        logic [31:0]  addr;
        logic [255:0] line;
    } exp_t;

    exp_t         sb[$];
    int           n_checks = 0;
    int           n_fail   = 0;
    logic [255:0] last_line = '0;   // line buffer content the bench expects

    // Serve one expected burst from the scoreboard; gap_len idle cycles are
    // inserted before beat gap_beat. exp_wait = cycles from call until the
    // burst strobe is expected to appear.
    task automatic run_burst(input int gap_beat, input int gap_len, input int exp_wait);
        exp_t e;
        int   w;
        if (sb.size() == 0) begin
            n_checks++; n_fail++;
            $display("FAIL sb_empty: no expected burst queued");
            return;
        end
        e = sb.pop_front();
        w = 0;
        while (!(bmem_read || bmem_write) && w < 20) begin
            @(posedge clk); #1; w++;
        end
        n_checks++;
        if (!(bmem_read || bmem_write)) begin
            n_fail++;
            $display("FAIL burst_timeout: no bmem strobe within %0d cycles for addr %h", w, e.addr);
            return;
        end
        n_checks++;
        if (w !== exp_wait) begin
            n_fail++;
            $display("FAIL grant_latency: got %0d cycles, expected %0d (addr %h)", w, exp_wait, e.addr);
        end
        for (int b = 0; b < 4; b++) begin
            if (b == gap_beat) begin
                for (int g = 0; g < gap_len; g++) begin
                    bmem_resp = 1'b0;
                    @(posedge clk); #1;
                    n_checks++;
                    if (bmem_write !== e.is_wr || bmem_read !== !e.is_wr ||
                        (e.is_wr && bmem_wdata !== e.line[64*b +: 64])) begin
                        n_fail++;
                        $display("FAIL gap_hold: beat %0d rd=%b wr=%b wdata=%h, expected wdata %h",
                                 b, bmem_read, bmem_write, bmem_wdata, e.line[64*b +: 64]);
                    end
                end
            end
            bmem_resp  = 1'b1;
            bmem_rdata = e.is_wr ? 64'($urandom()) : e.line[64*b +: 64];
            n_checks++;
            if (bmem_read !== !e.is_wr || bmem_write !== e.is_wr || bmem_address !== e.addr) begin
                n_fail++;
                $display("FAIL burst_strobe: beat %0d rd=%b wr=%b addr=%h, expected wr=%b addr=%h",
                         b, bmem_read, bmem_write, bmem_address, e.is_wr, e.addr);
            end
            if (e.is_wr) begin
                n_checks++;
                if (bmem_wdata !== e.line[64*b +: 64]) begin
                    n_fail++;
                    $display("FAIL wdata_beat%0d: got %h, expected %h", b, bmem_wdata, e.line[64*b +: 64]);
                end
            end
            @(posedge clk); #1;
        end
        bmem_resp = 1'b0;
        // DONE cycle
        n_checks++;
        if (bmem_read !== 1'b0 || bmem_write !== 1'b0 ||
            dcache_pmem_resp !== e.is_d || icache_pmem_resp !== !e.is_d) begin
            n_fail++;
            $display("FAIL done_resp: rd=%b wr=%b dresp=%b iresp=%b, expected dresp=%b iresp=%b",
                     bmem_read, bmem_write, dcache_pmem_resp, icache_pmem_resp, e.is_d, !e.is_d);
        end
        if (!e.is_wr) begin
            last_line = e.line;
            n_checks++;
            if ((e.is_d ? dcache_pmem_rdata : icache_pmem_rdata) !== e.line) begin
                n_fail++;
                $display("FAIL done_rdata: got %h, expected %h",
                         e.is_d ? dcache_pmem_rdata : icache_pmem_rdata, e.line);
            end
        end
        if (e.is_d) begin
            dcache_pmem_read  = 1'b0;
            dcache_pmem_write = 1'b0;
        end else begin
            icache_pmem_read = 1'b0;
        end
        @(posedge clk); #1;
        n_checks++;
        if (icache_pmem_resp !== 1'b0 || dcache_pmem_resp !== 1'b0) begin
            n_fail++;
            $display("FAIL resp_pulse_width: iresp=%b dresp=%b one cycle after DONE, expected 0/0",
                     icache_pmem_resp, dcache_pmem_resp);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        icache_pmem_address = '0; icache_pmem_read = 1'b0;
        dcache_pmem_address = '0; dcache_pmem_read = 1'b0;
        dcache_pmem_write = 1'b0; dcache_pmem_wdata = '0;
        bmem_rdata = '0; bmem_resp = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if ({bmem_read, bmem_write, icache_pmem_resp, dcache_pmem_resp} !== 4'b0) begin
            n_fail++;
            $display("FAIL reset_ctrl: rd/wr/iresp/dresp=%b, expected 0000",
                     {bmem_read, bmem_write, icache_pmem_resp, dcache_pmem_resp});
        end
        n_checks++;
        if (bmem_address !== 32'h0 || bmem_wdata !== 64'h0) begin
            n_fail++;
            $display("FAIL reset_bus: addr=%h wdata=%h, expected 0", bmem_address, bmem_wdata);
        end
        n_checks++;
        if (icache_pmem_rdata !== 256'h0 || dcache_pmem_rdata !== 256'h0) begin
            n_fail++;
            $display("FAIL reset_rdata: i=%h d=%h, expected 0", icache_pmem_rdata, dcache_pmem_rdata);
        end
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_i_read();
        exp_t e;
        e.is_d = 1'b0; e.is_wr = 1'b0; e.addr = 32'h0000_1220;
        e.line = {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
                  64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111};
        sb.push_back(e);
        icache_pmem_address = 32'h0000_1234;
        icache_pmem_read    = 1'b1;
        run_burst(-1, 0, 1);
    endtask

    task automatic test_stray_resp();
        for (int i = 0; i < 3; i++) begin
            bmem_resp  = 1'b1;
            bmem_rdata = {$urandom(), $urandom()};
            @(posedge clk); #1;
            n_checks++;
            if (bmem_read !== 1'b0 || bmem_write !== 1'b0 || icache_pmem_resp !== 1'b0 ||
                dcache_pmem_resp !== 1'b0 || icache_pmem_rdata !== last_line) begin
                n_fail++;
                $display("FAIL stray_resp_idle: rd=%b wr=%b iresp=%b dresp=%b rdata=%h, expected idle, rdata %h",
                         bmem_read, bmem_write, icache_pmem_resp, dcache_pmem_resp,
                         icache_pmem_rdata, last_line);
            end
        end
        bmem_resp = 1'b0;
    endtask

    task automatic test_arbitration();
        exp_t d, i;
        d.is_d = 1'b1; d.is_wr = 1'b0; d.addr = 32'h0000_0200;
        d.line = {64'hD3D3_0000_0000_0003, 64'hD2D2_0000_0000_0002,
                  64'hD1D1_0000_0000_0001, 64'hD0D0_0000_0000_0000};
        i.is_d = 1'b0; i.is_wr = 1'b0; i.addr = 32'h0000_0100;
        i.line = {64'hA3A3_0000_0000_0003, 64'hA2A2_0000_0000_0002,
                  64'hA1A1_0000_0000_0001, 64'hA0A0_0000_0000_0000};
        sb.push_back(d);
        sb.push_back(i);
        icache_pmem_address = 32'h0000_0100; icache_pmem_read = 1'b1;
        dcache_pmem_address = 32'h0000_0200; dcache_pmem_read = 1'b1;
        run_burst(-1, 0, 1);   // D first
        run_burst(-1, 0, 1);   // I granted in the IDLE cycle after D's DONE
    endtask

    task automatic test_d_writeback();
        exp_t e;
        e.is_d = 1'b1; e.is_wr = 1'b1; e.addr = 32'h0000_0A00;
        e.line = 256'h0123456789ABCDEF_FEDCBA9876543210_0F1E2D3C4B5A6978_8796A5B4C3D2E1F0;
        sb.push_back(e);
        dcache_pmem_address = 32'h0000_0A1C;
        dcache_pmem_wdata   = e.line;
        dcache_pmem_write   = 1'b1;
        run_burst(2, 2, 1);
    endtask

    task automatic test_rd_wr_together();
        exp_t e;
        e.is_d = 1'b1; e.is_wr = 1'b1; e.addr = 32'h0000_0040;
        e.line = {64'hCAFE_0003_0003_0003, 64'hCAFE_0002_0002_0002,
                  64'hCAFE_0001_0001_0001, 64'hCAFE_0000_0000_0000};
        sb.push_back(e);
        dcache_pmem_address = 32'h0000_0040;
        dcache_pmem_wdata   = e.line;
        dcache_pmem_read    = 1'b1;
        dcache_pmem_write   = 1'b1;
        run_burst(-1, 0, 1);
    endtask

    task automatic test_reset_mid_burst();
        exp_t e;
        int   w;
        icache_pmem_address = 32'h0000_0300;
        icache_pmem_read    = 1'b1;
        w = 0;
        while (!bmem_read && w < 20) begin
            @(posedge clk); #1; w++;
        end
        n_checks++;
        if (bmem_read !== 1'b1) begin
            n_fail++;
            $display("FAIL midrst_grant: bmem_read=%b after %0d cycles, expected 1", bmem_read, w);
        end
        for (int b = 0; b < 2; b++) begin
            bmem_resp  = 1'b1;
            bmem_rdata = 64'hBAD0_0000_0000_0000 | 64'(b);
            @(posedge clk); #1;
        end
        bmem_resp = 1'b0;
        rst = 1'b1;
        icache_pmem_read = 1'b0;
        @(posedge clk); #1;
        n_checks++;
        if ({bmem_read, bmem_write, icache_pmem_resp, dcache_pmem_resp} !== 4'b0 ||
            bmem_address !== 32'h0 || bmem_wdata !== 64'h0) begin
            n_fail++;
            $display("FAIL midrst_outputs: rd=%b wr=%b iresp=%b dresp=%b addr=%h wdata=%h, expected all 0",
                     bmem_read, bmem_write, icache_pmem_resp, dcache_pmem_resp, bmem_address, bmem_wdata);
        end
        n_checks++;
        if (icache_pmem_rdata !== 256'h0) begin
            n_fail++;
            $display("FAIL midrst_rdata: got %h, expected 0", icache_pmem_rdata);
        end
        rst = 1'b0;
        @(posedge clk); #1;
        n_checks++;
        if (bmem_read !== 1'b0 || icache_pmem_resp !== 1'b0) begin
            n_fail++;
            $display("FAIL midrst_idle: rd=%b iresp=%b after reset release, expected 0/0",
                     bmem_read, icache_pmem_resp);
        end
        e.is_d = 1'b1; e.is_wr = 1'b0; e.addr = 32'h0000_0080;
        e.line = {64'h5555_0000_0000_0003, 64'h5555_0000_0000_0002,
                  64'h5555_0000_0000_0001, 64'h5555_0000_0000_0000};
        sb.push_back(e);
        dcache_pmem_address = 32'h0000_0088;
        dcache_pmem_read    = 1'b1;
        run_burst(-1, 0, 1);
    endtask

    initial begin
        test_reset();
        test_i_read();
        test_stray_resp();
        test_arbitration();
        test_d_writeback();
        test_rd_wr_together();
        test_reset_mid_burst();
        test_stray_resp();
        n_checks++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL sb_drain: %0d expected bursts never served, expected 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
